// File: rtl/trig_pulse_sequencer_if.sv
// Link between the pulse sequencer and the interval counter it drives.
//   cnt_start : one-cycle start strobe to the counter
//   cnt_n     : interval length loaded by the counter on start
//   cnt_state : counter state, 00 = zero/idle, 01 = counting, 10 = overflow (one cycle)
// master = sequencer side, slave = counter side.
interface trig_pulse_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             cnt_start;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       cnt_state;

  modport master (
    output cnt_start,
    output cnt_n,
    input  cnt_state
  );

  modport slave (
    input  cnt_start,
    input  cnt_n,
    output cnt_state
  );
endinterface

// File: rtl/trig_pulse_sequencer.sv
// Trigger-driven pulse-train sequencer. An accepted trigger edge programs the interval
// counter with an optional delay, then alternates gate-high and gap intervals for the
// latched number of pulses, advancing only when the counter reports overflow.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   arm          : triggers accepted only while high; dropping it aborts a sequence
//   trig_in      : trigger, rising edge used
//   delay/width/gap/n_pulses : interval settings, latched at trigger acceptance
//   cnt_if       : counter link (start, N out; 2-bit state in)
//   gate_out     : high during gate intervals
//   busy         : sequence in progress (DELAY/GATE/GAP/DONE)
//   done         : one-cycle pulse on normal completion
//   pulse_idx    : index of the current pulse
//   missed_trig  : sticky, set when a trigger edge is ignored
module trig_pulse_sequencer #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned PULSE_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arm,
  input  logic                   trig_in,
  input  logic [CNT_W-1:0]       delay,
  input  logic [CNT_W-1:0]       width,
  input  logic [CNT_W-1:0]       gap,
  input  logic [PULSE_W-1:0]     n_pulses,
  trig_pulse_sequencer_if.master cnt_if,
  output logic                   gate_out,
  output logic                   busy,
  output logic                   done,
  output logic [PULSE_W-1:0]     pulse_idx,
  output logic                   missed_trig
);

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StDelay,
    StGate,
    StGap,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic                 trig_d_q;
  logic [CNT_W-1:0]     width_q, width_d;
  logic [CNT_W-1:0]     gap_q, gap_d;
  logic [PULSE_W-1:0]   last_idx_q, last_idx_d;
  logic                 cnt_start_q, cnt_start_d;
  logic [CNT_W-1:0]     cnt_n_q, cnt_n_d;
  logic                 gate_q, gate_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [PULSE_W-1:0]   pulse_idx_q, pulse_idx_d;
  logic                 missed_q, missed_d;

  logic trig_edge;
  logic cnt_ovf;
  logic cnt_idle;
  logic seq_busy;

  always_comb begin
    trig_edge = trig_in & ~trig_d_q;
    cnt_ovf   = (cnt_if.cnt_state == 2'b10);
    cnt_idle  = (cnt_if.cnt_state == 2'b00);
    seq_busy  = (state_q inside {StDelay, StGate, StGap, StDone});

    state_d     = state_q;
    width_d     = width_q;
    gap_d       = gap_q;
    last_idx_d  = last_idx_q;
    cnt_start_d = 1'b0;
    cnt_n_d     = cnt_n_q;
    gate_d      = gate_q;
    done_d      = 1'b0;
    pulse_idx_d = pulse_idx_q;
    missed_d    = missed_q;

    // An edge is dropped either mid-sequence or while the counter is still busy
    // finishing an interval left over from an abort.
    if (trig_edge && (seq_busy || (state_q == StArmed && arm && !cnt_idle))) begin
      missed_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (arm) begin
          state_d = StArmed;
        end
      end

      StArmed: begin
        if (!arm) begin
          state_d = StIdle;
        end else if (trig_edge && cnt_idle) begin
          width_d     = width;
          gap_d       = gap;
          // Store n-1 so the end-of-train test is a plain compare; 0 pulses acts as 1.
          last_idx_d  = (n_pulses == '0) ? '0 : n_pulses - 1'b1;
          pulse_idx_d = '0;
          cnt_start_d = 1'b1;
          if (delay != '0) begin
            cnt_n_d = delay;
            state_d = StDelay;
          end else begin
            cnt_n_d = width;
            gate_d  = 1'b1;
            state_d = StGate;
          end
        end
      end

      StDelay: begin
        if (!arm) begin
          state_d = StIdle;
          gate_d  = 1'b0;
        end else if (cnt_ovf) begin
          cnt_start_d = 1'b1;
          cnt_n_d     = width_q;
          gate_d      = 1'b1;
          state_d     = StGate;
        end
      end

      StGate: begin
        if (!arm) begin
          state_d = StIdle;
          gate_d  = 1'b0;
        end else if (cnt_ovf) begin
          gate_d = 1'b0;
          if (pulse_idx_q == last_idx_q) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_start_d = 1'b1;
            cnt_n_d     = gap_q;
            state_d     = StGap;
          end
        end
      end

      StGap: begin
        if (!arm) begin
          state_d = StIdle;
          gate_d  = 1'b0;
        end else if (cnt_ovf) begin
          pulse_idx_d = pulse_idx_q + 1'b1;
          cnt_start_d = 1'b1;
          cnt_n_d     = width_q;
          gate_d      = 1'b1;
          state_d     = StGate;
        end
      end

      StDone: begin
        state_d = arm ? StArmed : StIdle;
      end

      default: begin
        state_d = StIdle;
        gate_d  = 1'b0;
      end
    endcase

    // Registered from the next state so busy lines up with the state it describes.
    busy_d = (state_d inside {StDelay, StGate, StGap, StDone});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      trig_d_q    <= 1'b0;
      width_q     <= '0;
      gap_q       <= '0;
      last_idx_q  <= '0;
      cnt_start_q <= 1'b0;
      cnt_n_q     <= '0;
      gate_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pulse_idx_q <= '0;
      missed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_d_q    <= trig_in;
      width_q     <= width_d;
      gap_q       <= gap_d;
      last_idx_q  <= last_idx_d;
      cnt_start_q <= cnt_start_d;
      cnt_n_q     <= cnt_n_d;
      gate_q      <= gate_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pulse_idx_q <= pulse_idx_d;
      missed_q    <= missed_d;
    end
  end

  assign cnt_if.cnt_start = cnt_start_q;
  assign cnt_if.cnt_n     = cnt_n_q;
  assign gate_out         = gate_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pulse_idx        = pulse_idx_q;
  assign missed_trig      = missed_q;

endmodule

// File: tb/tb_trig_pulse_sequencer.sv
// Bench for trig_pulse_sequencer: a simple interval-counter stub, directed scenarios with
// literal expectations, then random stimulus checked every cycle against an
// interval-list model of the pulse train.
module tb_trig_pulse_sequencer;
  localparam int unsigned CW = 32;
  localparam int unsigned PW = 16;

  localparam logic [1:0] KDelay = 2'd0;
  localparam logic [1:0] KGate  = 2'd1;
  localparam logic [1:0] KGap   = 2'd2;

  typedef struct packed {
    logic [31:0] n;
    logic [1:0]  kind;
  } ivl_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          trig_in;
  logic [CW-1:0] delay, width, gap;
  logic [PW-1:0] n_pulses;
  logic          gate_out, busy, done, missed_trig;
  logic [PW-1:0] pulse_idx;

  always #5 clk = ~clk;

  trig_pulse_sequencer_if #(.CNT_W(CW)) cif ();

  trig_pulse_sequencer #(
    .CNT_W  (CW),
    .PULSE_W(PW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .trig_in    (trig_in),
    .delay      (delay),
    .width      (width),
    .gap        (gap),
    .n_pulses   (n_pulses),
    .cnt_if     (cif),
    .gate_out   (gate_out),
    .busy       (busy),
    .done       (done),
    .pulse_idx  (pulse_idx),
    .missed_trig(missed_trig)
  );

  // Counter stub: start loads N, N cycles of 01, one cycle of 10, then 00.
  logic [1:0]  stub_st;
  logic [31:0] stub_rem;
  always @(posedge clk) begin
    if (rst) begin
      stub_st  <= 2'b00;
      stub_rem <= '0;
    end else if (cif.cnt_start) begin
      stub_rem <= cif.cnt_n;
      stub_st  <= (cif.cnt_n == 0) ? 2'b10 : 2'b01;
    end else if (stub_st == 2'b01) begin
      if (stub_rem <= 1) stub_st <= 2'b10;
      else stub_rem <= stub_rem - 1;
    end else if (stub_st == 2'b10) begin
      stub_st <= 2'b00;
    end
  end
  assign cif.cnt_state = stub_st;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Observation log of DUT activity, used by the directed literal checks.
  logic [31:0] start_log[$];
  int          gate_rises = 0;
  int          done_seen  = 0;
  bit          chk_en     = 0;

  function automatic logic [31:0] start_at(input int i);
    if (i < start_log.size()) return start_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Model state: the remaining interval list of the running train.
  ivl_t        q[$];
  bit          m_armed, m_seq, m_donec, m_tprev;
  logic        e_start, e_gate, e_busy, e_done, e_missed;
  logic [31:0] e_n;
  int          e_idx;

  initial begin
    bit   t_edge;
    bit   gate_prev;
    ivl_t cur;
    int   np;
    m_armed = 0; m_seq = 0; m_donec = 0; m_tprev = 0;
    e_start = 0; e_gate = 0; e_busy = 0; e_done = 0; e_missed = 0; e_n = 0; e_idx = 0;
    gate_prev = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cnt_start", cif.cnt_start, e_start);
        chk("cnt_n", cif.cnt_n, e_n);
        chk("gate_out", gate_out, e_gate);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("pulse_idx", pulse_idx, e_idx);
        chk("missed_trig", missed_trig, e_missed);
        if (cif.cnt_start) start_log.push_back(cif.cnt_n);
        if (gate_out && !gate_prev) gate_rises++;
        if (done) done_seen++;
        gate_prev = gate_out;
      end
      if (rst) begin
        q.delete();
        m_armed = 0; m_seq = 0; m_donec = 0; m_tprev = 0;
        e_start = 0; e_gate = 0; e_busy = 0; e_done = 0; e_missed = 0; e_n = 0; e_idx = 0;
      end else begin
        t_edge  = trig_in && !m_tprev;
        if (t_edge && ((m_seq || m_donec) || (m_armed && arm && cif.cnt_state != 2'b00)))
          e_missed = 1;
        e_start = 0;
        e_done  = 0;
        if (m_donec) begin
          m_donec = 0;
          m_armed = arm;
        end else if (m_seq) begin
          if (!arm) begin
            m_seq  = 0;
            e_gate = 0;
            q.delete();
          end else if (cif.cnt_state == 2'b10) begin
            cur = q.pop_front();
            if (cur.kind == KGap) e_idx++;
            if (q.size() == 0) begin
              m_seq   = 0;
              m_donec = 1;
              e_done  = 1;
              e_gate  = 0;
            end else begin
              e_start = 1;
              e_n     = q[0].n;
              e_gate  = (q[0].kind == KGate);
            end
          end
        end else if (m_armed) begin
          if (!arm) begin
            m_armed = 0;
          end else if (t_edge && cif.cnt_state == 2'b00) begin
            q.delete();
            if (delay != 0) q.push_back('{n: delay, kind: KDelay});
            np = (n_pulses == 0) ? 1 : int'(n_pulses);
            for (int i = 0; i < np; i++) begin
              q.push_back('{n: width, kind: KGate});
              if (i < np - 1) q.push_back('{n: gap, kind: KGap});
            end
            m_armed = 0;
            m_seq   = 1;
            e_idx   = 0;
            e_start = 1;
            e_n     = q[0].n;
            e_gate  = (q[0].kind == KGate);
          end
        end else if (arm) begin
          m_armed = 1;
        end
        m_tprev = trig_in;
        e_busy  = m_seq || m_donec;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig_in = 1'b1;
    step(1);
    trig_in = 1'b0;
  endtask

  initial begin
    int sb, gb, db;
    rst = 1'b1; arm = 1'b0; trig_in = 1'b0;
    delay = '0; width = '0; gap = '0; n_pulses = '0;
    step(2);
    chk_en = 1;
    step(1);
    chk("reset_cnt_start", cif.cnt_start, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    arm = 1'b1;
    step(2);

    // Basic train: delay 5, width 3, gap 4, two pulses.
    delay = 5; width = 3; gap = 4; n_pulses = 2;
    sb = start_log.size(); gb = gate_rises; db = done_seen;
    pulse_trig();
    step(40);
    chk("basic_nstarts", start_log.size() - sb, 4);
    chk("basic_start0", start_at(sb), 5);
    chk("basic_start1", start_at(sb + 1), 3);
    chk("basic_start2", start_at(sb + 2), 4);
    chk("basic_start3", start_at(sb + 3), 3);
    chk("basic_gates", gate_rises - gb, 2);
    chk("basic_done", done_seen - db, 1);
    chk("basic_idx", pulse_idx, 1);
    chk("basic_busy_end", busy, 0);

    // No delay, n_pulses 0 behaves as one pulse.
    delay = 0; width = 4; n_pulses = 0;
    sb = start_log.size(); gb = gate_rises; db = done_seen;
    pulse_trig();
    step(20);
    chk("nodly_nstarts", start_log.size() - sb, 1);
    chk("nodly_start0", start_at(sb), 4);
    chk("nodly_gates", gate_rises - gb, 1);
    chk("nodly_done", done_seen - db, 1);

    // Retrigger mid-train and a width change: both must not affect the train.
    delay = 2; width = 3; gap = 2; n_pulses = 3;
    sb = start_log.size(); gb = gate_rises;
    pulse_trig();
    step(4);
    width = 9;
    pulse_trig();
    step(40);
    chk("midtrig_missed", missed_trig, 1);
    chk("midtrig_nstarts", start_log.size() - sb, 6);
    for (int i = 0; i < 6; i++) chk("midtrig_start", start_at(sb + i), (i % 2 == 0) ? 2 : 3);
    chk("midtrig_gates", gate_rises - gb, 3);
    width = 3;

    // Abort in GATE, then retrigger while the counter is still running.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_missed_clear", missed_trig, 0);
    step(2);
    delay = 0; width = 20; n_pulses = 1;
    sb = start_log.size(); db = done_seen;
    pulse_trig();
    step(5);
    arm = 1'b0;
    step(1);
    chk("abort_gate", gate_out, 0);
    chk("abort_busy", busy, 0);
    arm = 1'b1;
    step(2);
    pulse_trig();
    step(1);
    chk("abort_retrig_missed", missed_trig, 1);
    step(30);
    chk("abort_nstarts", start_log.size() - sb, 1);
    chk("abort_no_done", done_seen - db, 0);

    // Reset during GAP.
    delay = 0; width = 2; gap = 30; n_pulses = 2;
    pulse_trig();
    step(8);
    rst = 1'b1;
    step(1);
    chk("rstgap_cnt_start", cif.cnt_start, 0);
    chk("rstgap_cnt_n", cif.cnt_n, 0);
    chk("rstgap_gate", gate_out, 0);
    chk("rstgap_busy", busy, 0);
    chk("rstgap_done", done, 0);
    chk("rstgap_idx", pulse_idx, 0);
    chk("rstgap_missed", missed_trig, 0);
    rst = 1'b0;
    step(2);

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (arm) arm = ($urandom_range(0, 99) >= 2);
      else arm = ($urandom_range(0, 99) < 30);
      trig_in = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 19) == 0) begin
        delay    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
        width    = $urandom_range(0, 5);
        gap      = $urandom_range(0, 5);
        n_pulses = PW'($urandom_range(0, 4));
      end
      step(1);
    end
    rst = 1'b0; arm = 1'b0; trig_in = 1'b0;
    step(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trig_pulse_sequencer.md
# trig_pulse_sequencer

Trigger-driven pulse-train sequencer that sits directly upstream of the interval counter, which has a start/N/2-bit-state interface. On an armed trigger edge it programs the counter with a delay interval, then alternates gate-high and gap intervals for a programmed number of pulses. It advances only on the counter's overflow state code. It drives the counter's `start` and `N`, consumes the counter's 2-bit state output, and produces a gate signal for the downstream output path.

## Interface
- `CNT_W`, default 32: width of the interval values and `cnt_n`.
- `PULSE_W`, default 16: width of the pulse count and index.
- `clk`  in  1: single clock; everything is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `arm`  in  1: level. Triggers are accepted only while high. Deasserting it aborts a sequence.
- `trig_in`  in  1: synchronous trigger; its rising edge is used.
- `delay`  in  CNT_W: N value for the initial delay interval.
- `width`  in  CNT_W: N value for each gate-high interval.
- `gap`  in  CNT_W: N value for each gap between pulses.
- `n_pulses`  in  PULSE_W: number of gate pulses; 0 is treated as 1.
- `cnt_state`  in  2: counter state. 00 = zero (idle), 01 = counting, 10 = overflow (one cycle).
- `cnt_start`  out  1: start pulse to the counter.
- `cnt_n`  out  CNT_W: N value for the counter.
- `gate_out`  out  1: high during gate intervals.
- `busy`  out  1: high in any state other than IDLE or ARMED.
- `done`  out  1: one-cycle pulse when a sequence completes normally.
- `pulse_idx`  out  PULSE_W: index of the current pulse, starting at 0.
- `missed_trig`  out  1: sticky flag; set when a trigger edge is ignored.

## Operation
- All outputs are registered.
- Reset values: `cnt_start`=0, `cnt_n`=0, `gate_out`=0, `busy`=0, `done`=0, `pulse_idx`=0, `missed_trig`=0. The FSM resets to IDLE and the internal `trig_d` register to 0.
- Edge detect: `edge = trig_in & ~trig_d`, with `trig_d` registered every cycle.
- FSM states: IDLE, ARMED, DELAY, GATE, GAP, DONE.
- IDLE: go to ARMED when `arm`=1.
- ARMED:
  - If `arm`=0, go to IDLE.
  - On `edge` with `cnt_state`=00: latch `delay`, `width`, `gap` and `n_pulses` (0 becomes 1). Set `pulse_idx`=0.
    - If the latched delay is nonzero: issue a start with `cnt_n`=delay and go to DELAY.
    - If the latched delay is 0: issue a start with `cnt_n`=width, set `gate_out`=1 and go to GATE.
  - On `edge` with `cnt_state`≠00: ignore the edge, set `missed_trig`, stay in ARMED.
- Issuing a start means `cnt_start`=1 for exactly one cycle. A start is issued only from the cycle after `cnt_state`=10 is sampled, or from ARMED with `cnt_state`=00.
- DELAY: on `cnt_state`=10, issue a start with `cnt_n`=width, set `gate_out`=1 and go to GATE.
- GATE: on `cnt_state`=10, set `gate_out`=0, then:
  - If `pulse_idx` = latched n−1: go to DONE.
  - Otherwise: issue a start with `cnt_n`=gap and go to GAP.
- GAP: on `cnt_state`=10, increment `pulse_idx`, issue a start with `cnt_n`=width, set `gate_out`=1 and go to GATE.
- DONE: `done`=1 for one cycle, then go to ARMED if `arm`=1, else IDLE. Trigger edges that arrive while `busy` is high set `missed_trig`.
- Abort: if `arm`=0 in DELAY, GATE or GAP, go to IDLE on the next edge with `gate_out`=0, `cnt_start`=0 and no `done`. Any counter interval already running is left to finish. The next trigger is accepted only once `cnt_state`=00.
- `missed_trig` clears only on `rst`.
- `cnt_n` holds its last value between starts.
- Register inputs are sampled only at trigger acceptance; changes mid-sequence have no effect.

## Timing
- Trigger edge present at cycle T (`trig_in`=1, `trig_d`=0) → `cnt_start`=1 and `cnt_n` valid in cycle T+1. `busy`=1 from T+1.
- `cnt_state`=10 sampled at cycle X → the next `cnt_start` and any `gate_out` change appear in cycle X+1, when the counter is back in state 00.
- `gate_out` rises and falls in the same cycle as the corresponding counter start or overflow response.
- `done` is asserted one cycle after the final GATE overflow is sampled. `busy` drops in the cycle after `done`.
- `rst` asserted mid-sequence → all outputs take their reset values on the next edge.
- Simultaneous `arm` deassert and `cnt_state`=10: abort wins; no start is issued.

## Test plan
- Basic sequence: arm=1, delay=5, width=3, gap=4, n_pulses=2, trigger edge → one start with N=5, then starts with N=3, N=4, N=3. Two `gate_out` pulses; `pulse_idx` goes 0 then 1; one `done` pulse; back to ARMED.
- delay=0, n_pulses=0 → first start carries N=width; exactly one gate pulse; then `done`.
- Trigger edge during a sequence, and an edge in ARMED while `cnt_state`=01 → both ignored, `missed_trig`=1 and it stays set; sequence otherwise unaffected.
- Drop `arm` mid-GATE → `gate_out`=0 next cycle, no further `cnt_start`, no `done`. A retrigger while `cnt_state`≠00 is ignored.
- Change `width` mid-sequence from 3 to 9 → all gate intervals still use N=3.
- Assert `rst` during GAP → all outputs at reset values next cycle; FSM in IDLE.
